// File: rtl/ibex_rf_write_arbiter_if.sv
// Request, register-file write port and read-forwarding signals of ibex_rf_write_arbiter.
interface ibex_rf_write_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 lsu_ready_o;

  logic                 ex_valid_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ex_ready_o;

  logic [4:0]           waddr_a_o;
  logic [DataWidth-1:0] wdata_a_o;
  logic                 we_a_o;

  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 fwd_a_valid_o;
  logic                 fwd_b_valid_o;
  logic [DataWidth-1:0] fwd_a_data_o;
  logic [DataWidth-1:0] fwd_b_data_o;

  logic                 pending_o;
  logic                 err_o;

  // Arbiter side
  modport slave (
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output lsu_ready_o,
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    output ex_ready_o,
    output waddr_a_o, wdata_a_o, we_a_o,
    input  raddr_a_i, raddr_b_i,
    output fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o,
    output pending_o, err_o
  );

  // Requester / register-file side
  modport master (
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  lsu_ready_o,
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  ex_ready_o,
    input  waddr_a_o, wdata_a_o, we_a_o,
    output raddr_a_i, raddr_b_i,
    input  fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o,
    input  pending_o, err_o
  );
endinterface

// File: rtl/ibex_rf_write_arbiter.sv
// Merges LSU and EX writebacks onto the single register-file write port in program order,
// with a small in-order FIFO for collisions and read forwarding of pending writes.
module ibex_rf_write_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ibex_rf_write_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned SpcW = CntW + 1;

  typedef struct packed {
    logic [4:0]           waddr;
    logic [DataWidth-1:0] wdata;
  } wr_req_t;

  wr_req_t         mem_q [Depth];
  wr_req_t         mem_d [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            stall_q, stall_d;
  logic            err_q, err_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  wr_req_t         lsu_req, ex_req;
  logic            empty, pop;
  logic            lsu_need, ex_need, lsu_ready, ex_ready, lsu_acc, ex_acc;
  logic [SpcW-1:0] space, demand;

  assign lsu_req  = {bus.lsu_waddr_i, bus.lsu_wdata_i};
  assign ex_req   = {bus.ex_waddr_i, bus.ex_wdata_i};
  assign empty    = (count_q == '0);
  assign pop      = !empty;
  assign lsu_need = bus.lsu_valid_i && (bus.lsu_waddr_i != 5'd0);
  assign ex_need  = bus.ex_valid_i && (bus.ex_waddr_i != 5'd0);

  // The head always pops, so a non-empty FIFO frees one slot this cycle
  assign space     = SpcW'(Depth) - SpcW'(count_q) + SpcW'(pop);
  assign lsu_ready = !lsu_need || (space != '0) || empty;
  assign lsu_acc   = lsu_need && lsu_ready;
  assign demand    = SpcW'(1) + SpcW'(lsu_acc) - SpcW'(empty);
  assign ex_ready  = !ex_need || (demand <= space);
  assign ex_acc    = ex_need && ex_ready;

  wr_req_t    wr_port, enq0, enq1;
  logic       wr_en;
  logic [1:0] enq_cnt;

  // Write-port source and enqueue selection; LSU is always older than EX
  always_comb begin
    wr_port = '0;
    wr_en   = 1'b0;
    enq0    = lsu_req;
    enq1    = ex_req;
    enq_cnt = 2'd0;
    if (!empty) begin
      wr_port = mem_q[head_q];
      wr_en   = 1'b1;
      enq_cnt = 2'(lsu_acc) + 2'(ex_acc);
      if (!lsu_acc) enq0 = ex_req;
    end else if (lsu_acc) begin
      wr_port = lsu_req;
      wr_en   = 1'b1;
      enq0    = ex_req;
      enq_cnt = 2'(ex_acc);
    end else if (ex_acc) begin
      wr_port = ex_req;
      wr_en   = 1'b1;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = tail_q;
    if (enq_cnt != 2'd0) begin
      mem_d[tail_q] = enq0;
      tail_d        = ptr_inc(tail_q);
    end
    if (enq_cnt == 2'd2) begin
      mem_d[tail_d] = enq1;
      tail_d        = ptr_inc(tail_d);
    end
    count_d = count_q - CntW'(pop) + CntW'(enq_cnt);
    // Upstream must not keep a refused request waiting on a full FIFO
    stall_d = (count_q == CntW'(Depth)) &&
              ((bus.lsu_valid_i && !lsu_ready) || (bus.ex_valid_i && !ex_ready));
    err_d   = err_q || (stall_d && stall_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  logic [PtrW-1:0]      fwd_idx;
  logic                 fwd_a_valid, fwd_b_valid;
  logic [DataWidth-1:0] fwd_a_data, fwd_b_data;

  // Walk oldest to youngest so the youngest match is the one left standing
  always_comb begin
    fwd_a_valid = 1'b0;
    fwd_b_valid = 1'b0;
    fwd_a_data  = '0;
    fwd_b_data  = '0;
    fwd_idx     = head_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (CntW'(i) < count_q) begin
        if ((bus.raddr_a_i != 5'd0) && (mem_q[fwd_idx].waddr == bus.raddr_a_i)) begin
          fwd_a_valid = 1'b1;
          fwd_a_data  = mem_q[fwd_idx].wdata;
        end
        if ((bus.raddr_b_i != 5'd0) && (mem_q[fwd_idx].waddr == bus.raddr_b_i)) begin
          fwd_b_valid = 1'b1;
          fwd_b_data  = mem_q[fwd_idx].wdata;
        end
      end
      fwd_idx = ptr_inc(fwd_idx);
    end
  end

  assign bus.lsu_ready_o   = lsu_ready;
  assign bus.ex_ready_o    = ex_ready;
  assign bus.we_a_o        = wr_en && rst_ni;
  assign bus.waddr_a_o     = wr_port.waddr;
  assign bus.wdata_a_o     = wr_port.wdata;
  assign bus.fwd_a_valid_o = fwd_a_valid;
  assign bus.fwd_b_valid_o = fwd_b_valid;
  assign bus.fwd_a_data_o  = fwd_a_data;
  assign bus.fwd_b_data_o  = fwd_b_data;
  assign bus.pending_o     = !empty;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Self-checking bench for ibex_rf_write_arbiter: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ibex_rf_write_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_rf_write_arbiter_if #(.DataWidth(DW)) bus ();

  ibex_rf_write_arbiter #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_err        = 1'b0;
  bit   m_stall_prev = 1'b0;
  bit   m_eacc       = 1'b0;
  int   n_checks     = 0;
  int   n_pass       = 0;
  int   wr_cnt       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int m_space();
    int n = q.size();
    return DEPTH - n + ((n > 0) ? 1 : 0);
  endfunction

  function automatic bit m_lrdy();
    bit need = bus.lsu_valid_i && (bus.lsu_waddr_i != 5'd0);
    return !need || (m_space() >= 1) || (q.size() == 0);
  endfunction

  function automatic bit m_erdy();
    bit need  = bus.ex_valid_i && (bus.ex_waddr_i != 5'd0);
    bit lacc  = bus.lsu_valid_i && (bus.lsu_waddr_i != 5'd0) && m_lrdy();
    int dem   = 1 + (lacc ? 1 : 0) - ((q.size() == 0) ? 1 : 0);
    return !need || (dem <= m_space());
  endfunction

  task automatic model_step();
    ent_t inc[$];
    ent_t e;
    int   n     = q.size();
    bit   lr    = m_lrdy();
    bit   er    = m_erdy();
    bit   stall = (n == DEPTH) && ((bus.lsu_valid_i && !lr) || (bus.ex_valid_i && !er));
    if (stall && m_stall_prev) m_err = 1'b1;
    m_stall_prev = stall;
    m_eacc = bus.ex_valid_i && er;
    if (bus.lsu_valid_i && lr && bus.lsu_waddr_i != 5'd0) begin
      e.a = bus.lsu_waddr_i; e.d = bus.lsu_wdata_i; inc.push_back(e);
    end
    if (bus.ex_valid_i && er && bus.ex_waddr_i != 5'd0) begin
      e.a = bus.ex_waddr_i; e.d = bus.ex_wdata_i; inc.push_back(e);
    end
    if (n == 0 && inc.size() > 0) void'(inc.pop_front());
    if (n > 0) void'(q.pop_front());
    foreach (inc[i]) q.push_back(inc[i]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_err        = 1'b0;
      m_stall_prev = 1'b0;
      m_eacc       = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare_all();
    ent_t        w;
    bit          wv  = 1'b0;
    bit          lr  = m_lrdy();
    bit          er  = m_erdy();
    bit          fav = 1'b0, fbv = 1'b0;
    logic [31:0] fad = '0, fbd = '0;
    w.a = '0; w.d = '0;
    if (q.size() > 0) begin
      wv = 1'b1; w = q[0];
    end else if (bus.lsu_valid_i && bus.lsu_waddr_i != 5'd0 && lr) begin
      wv = 1'b1; w.a = bus.lsu_waddr_i; w.d = bus.lsu_wdata_i;
    end else if (bus.ex_valid_i && bus.ex_waddr_i != 5'd0 && er) begin
      wv = 1'b1; w.a = bus.ex_waddr_i; w.d = bus.ex_wdata_i;
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!fav && bus.raddr_a_i != 5'd0 && q[i].a == bus.raddr_a_i) begin fav = 1'b1; fad = q[i].d; end
      if (!fbv && bus.raddr_b_i != 5'd0 && q[i].a == bus.raddr_b_i) begin fbv = 1'b1; fbd = q[i].d; end
    end
    chk("lsu_ready", bus.lsu_ready_o, lr);
    chk("ex_ready", bus.ex_ready_o, er);
    chk("we_a", bus.we_a_o, wv);
    chk("waddr_a", bus.waddr_a_o, w.a);
    chk("wdata_a", bus.wdata_a_o, w.d);
    chk("fwd_a_valid", bus.fwd_a_valid_o, fav);
    chk("fwd_a_data", bus.fwd_a_data_o, fad);
    chk("fwd_b_valid", bus.fwd_b_valid_o, fbv);
    chk("fwd_b_data", bus.fwd_b_data_o, fbd);
    chk("pending", bus.pending_o, q.size() > 0);
    chk("err", bus.err_o, m_err);
  endtask

  always @(negedge clk) begin
    if (rst_n) compare_all();
    if (bus.we_a_o) wr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit ev, input logic [4:0] ea, input logic [31:0] ed);
    @(posedge clk); #1;
    bus.lsu_valid_i = lv; bus.lsu_waddr_i = la; bus.lsu_wdata_i = ld;
    bus.ex_valid_i  = ev; bus.ex_waddr_i  = ea; bus.ex_wdata_i  = ed;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    int base;
    bus.lsu_valid_i = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
    bus.ex_valid_i  = 1'b0; bus.ex_waddr_i  = '0; bus.ex_wdata_i  = '0;
    bus.raddr_a_i   = '0;   bus.raddr_b_i   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    settle();
    chk("rst_we", bus.we_a_o, 0);
    chk("rst_waddr", bus.waddr_a_o, 0);
    chk("rst_wdata", bus.wdata_a_o, 0);
    chk("rst_pending", bus.pending_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_fwd_a", bus.fwd_a_valid_o, 0);

    // Single EX write bypasses with zero latency
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    settle();
    chk("byp_we", bus.we_a_o, 1);
    chk("byp_waddr", bus.waddr_a_o, 5);
    chk("byp_wdata", bus.wdata_a_o, 32'h1234);
    chk("byp_pending", bus.pending_o, 0);
    idle(); settle();
    chk("byp_after_pending", bus.pending_o, 0);

    // Same-cycle LSU and EX to x3: LSU first, EX queued and forwarded next cycle
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    bus.raddr_a_i = 5'd3;
    settle();
    chk("col0_wdata", bus.wdata_a_o, 32'hAAAA);
    chk("col0_fwd_valid", bus.fwd_a_valid_o, 0);
    idle(); settle();
    chk("col1_we", bus.we_a_o, 1);
    chk("col1_wdata", bus.wdata_a_o, 32'hBBBB);
    chk("col1_fwd_valid", bus.fwd_a_valid_o, 1);
    chk("col1_fwd_data", bus.fwd_a_data_o, 32'hBBBB);
    idle(); settle();
    chk("col2_pending", bus.pending_o, 0);

    // Write to x0 is accepted and dropped
    bus.raddr_a_i = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    settle();
    chk("x0_ready", bus.ex_ready_o, 1);
    chk("x0_we", bus.we_a_o, 0);
    chk("x0_pending", bus.pending_o, 0);
    chk("x0_fwd", bus.fwd_a_valid_o, 0);

    // Two pending writes to x7: youngest forwarded
    bus.raddr_b_i = 5'd7;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    idle(); settle();
    chk("x7_both_fwd_data", bus.fwd_b_data_o, 32'h2);
    chk("x7_both_wdata", bus.wdata_a_o, 32'h1);
    idle(); settle();
    chk("x7_one_fwd_data", bus.fwd_b_data_o, 32'h2);
    chk("x7_one_fwd_valid", bus.fwd_b_valid_o, 1);
    idle(); settle();
    chk("x7_none_fwd_valid", bus.fwd_b_valid_o, 0);
    bus.raddr_b_i = 5'd0;

    // Both sources every cycle: fill, EX backpressure, overflow flag, exact write count
    base = wr_cnt;
    for (int k = 0; k < 6; k++) begin
      if (k == 0 || m_eacc)
        drive(1'b1, 5'(1 + 2 * k), 32'h100 + k, 1'b1, 5'(2 + 2 * k), 32'h200 + k);
      else
        drive(1'b1, 5'(1 + 2 * k), 32'h100 + k, 1'b1, bus.ex_waddr_i, bus.ex_wdata_i);
      if (k == 4) begin
        settle();
        chk("fill_ex_ready", bus.ex_ready_o, 0);
        chk("fill_lsu_ready", bus.lsu_ready_o, 1);
      end
    end
    idle(); settle();
    chk("fill_err", bus.err_o, 1);
    repeat (4) idle();
    idle(); settle();
    chk("fill_writes", wr_cnt - base, 10);
    chk("fill_drained", bus.pending_o, 0);

    // Reset with three writes pending
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    drive(1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6);
    idle();
    chk("pre_rst_pending", bus.pending_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", bus.we_a_o, 0);
    chk("rst_mid_pending", bus.pending_o, 0);
    chk("rst_mid_err", bus.err_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    base = wr_cnt;
    repeat (3) idle();
    settle();
    chk("rst_no_stale_writes", wr_cnt - base, 0);

    // Randomized traffic with held EX requests
    for (int c = 0; c < 400; c++) begin
      logic [4:0]  la = 5'($urandom_range(0, 7));
      logic [4:0]  ea = 5'($urandom_range(0, 7));
      logic [31:0] ld = $urandom;
      logic [31:0] ed = $urandom;
      bit          lv = ($urandom_range(0, 2) != 0);
      bit          ev = ($urandom_range(0, 2) != 0);
      if (bus.ex_valid_i && !m_eacc) begin
        ev = 1'b1; ea = bus.ex_waddr_i; ed = bus.ex_wdata_i;
      end
      drive(lv, la, ld, ev, ea, ed);
      bus.raddr_a_i = 5'($urandom_range(0, 7));
      bus.raddr_b_i = 5'($urandom_range(0, 7));
    end
    repeat (8) idle();
    settle();
    chk("final_drained", bus.pending_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
